// File: rtl/seg7_ascii_scan.sv
// seg7_ascii_scan
//   Time-multiplexed driver for a NUM_DIGITS-digit 7-segment display fed with
//   ASCII characters. Characters, decimal points and blink enables are held in
//   shadow registers that are refreshed only on LOAD. Each digit owns a slot of
//   CLK_DIV cycles. The first cycle of every slot is blanked so the previous
//   digit's pattern never ghosts onto the next anode. Brightness is a 16-step
//   PWM. Blinking toggles every BLINK_FRAMES full scans.
//
// Ports
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   DATA        ASCII characters, digit i = DATA[8i+7:8i], digit 0 rightmost
//   DP          per-digit decimal point request
//   LOAD        capture DATA/DP/BLINK_EN into the shadow registers
//   BLINK_EN    per-digit blink enable
//   BRIGHT      brightness, lit while pwm_cnt <= BRIGHT
//   ENABLE      0 forces the display dark; scanning keeps running
//   SEGMENT     registered segment drive {dp,g,f,e,d,c,b,a}
//   DIG         registered one-hot digit select
//   FRAME_DONE  one-cycle pulse after the last digit slot of a frame ends
module seg7_ascii_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [8*NUM_DIGITS-1:0] DATA,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    LOAD,
    input  logic [NUM_DIGITS-1:0]   BLINK_EN,
    input  logic [3:0]              BRIGHT,
    input  logic                    ENABLE,
    output logic [7:0]              SEGMENT,
    output logic [NUM_DIGITS-1:0]   DIG,
    output logic                    FRAME_DONE
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

    // Inactive levels of the pins, used both for reset and for dark cycles.
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]            sh_char [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blink;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [3:0]    pwm_cnt;

    logic slot_end;
    logic frame_end;
    logic blink_wrap;

    assign slot_end   = (presc == PRE_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign blink_wrap = frame_end && (frame_cnt == FR_LAST);

    // ------------------------------------------------------------------
    // Shadow registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_char[i] <= 8'h20;
            end
            sh_dp    <= '0;
            sh_blink <= '0;
        end else if (LOAD) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_char[i] <= DATA[8*i +: 8];
            end
            sh_dp    <= DP;
            sh_blink <= BLINK_EN;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: prescaler, digit index, frame/blink counters, PWM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= 4'd0;
            FRAME_DONE  <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 4'd1;
            FRAME_DONE <= frame_end;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            if (frame_end) begin
                frame_cnt <= blink_wrap ? '0 : frame_cnt + FW'(1);
            end
            // Phase flips on the same edge that ends the last frame of a
            // half-period, so the next frame already shows the new phase.
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // ------------------------------------------------------------------
    // Character decode, active-high {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [7:0] c);
        logic [7:0] u;
        logic [6:0] s;
        // Fold lowercase onto uppercase so letters are case-insensitive.
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h30:   s = 7'h3F; // 0
            8'h31:   s = 7'h06; // 1
            8'h32:   s = 7'h5B; // 2
            8'h33:   s = 7'h4F; // 3
            8'h34:   s = 7'h66; // 4
            8'h35:   s = 7'h6D; // 5
            8'h36:   s = 7'h7D; // 6
            8'h37:   s = 7'h07; // 7
            8'h38:   s = 7'h7F; // 8
            8'h39:   s = 7'h6F; // 9
            8'h41:   s = 7'h77; // A
            8'h42:   s = 7'h7C; // B
            8'h43:   s = 7'h39; // C
            8'h44:   s = 7'h5E; // D
            8'h45:   s = 7'h79; // E
            8'h46:   s = 7'h71; // F
            8'h48:   s = 7'h76; // H
            8'h4C:   s = 7'h38; // L
            8'h50:   s = 7'h73; // P
            8'h2D:   s = 7'h40; // -
            8'h5F:   s = 7'h08; // _
            default: s = 7'h00; // space and anything unsupported
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Output next-state
    // ------------------------------------------------------------------
    logic                  lit;
    logic [7:0]            seg_pat;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [7:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;

    always_comb begin
        seg_pat = {sh_dp[idx], decode(sh_char[idx])};
        dig_sel = NUM_DIGITS'(1) << idx;
        // Dark when disabled, outside the PWM window, in the slot's guard
        // cycle (presc == 0), or blanked by the blink phase.
        lit = ENABLE
              && (pwm_cnt <= BRIGHT)
              && (presc != '0)
              && !(blink_phase && sh_blink[idx]);
        seg_nxt = lit ? seg_pat : 8'h00;
        dig_nxt = lit ? dig_sel : '0;
        // Polarity is applied last, after all blanking decisions.
        if (SEG_ACTIVE_LOW != 0) seg_nxt = ~seg_nxt;
        if (DIG_ACTIVE_LOW != 0) dig_nxt = ~dig_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEGMENT <= SEG_OFF;
            DIG     <= DIG_OFF;
        end else begin
            SEGMENT <= seg_nxt;
            DIG     <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_ascii_scan.sv
// Directed bench for seg7_ascii_scan. Instance dut_a uses the short-slot
// configuration (CLK_DIV=4) for scan, decode, load, blink and coincidence
// vectors; dut_b uses CLK_DIV=64 for the brightness window. Both share inputs.
module tb_seg7_ascii_scan;

    logic        CLK;
    logic        RST_N;
    logic [31:0] DATA;
    logic [3:0]  DP;
    logic        LOAD;
    logic [3:0]  BLINK_EN;
    logic [3:0]  BRIGHT;
    logic        ENABLE;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;
    int t = 0;   // rising edges since the last reset release

    seg7_ascii_scan #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_a (
        .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DP(DP), .LOAD(LOAD),
        .BLINK_EN(BLINK_EN), .BRIGHT(BRIGHT), .ENABLE(ENABLE),
        .SEGMENT(seg_a), .DIG(dig_a), .FRAME_DONE(fd_a)
    );

    seg7_ascii_scan #(
        .NUM_DIGITS(4), .CLK_DIV(64), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_b (
        .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DP(DP), .LOAD(LOAD),
        .BLINK_EN(BLINK_EN), .BRIGHT(BRIGHT), .ENABLE(ENABLE),
        .SEGMENT(seg_b), .DIG(dig_b), .FRAME_DONE(fd_b)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        t = 0;
    endtask

    task automatic load(input logic [31:0] d, input logic [3:0] dp, input logic [3:0] be);
        DATA     = d;
        DP       = dp;
        BLINK_EN = be;
        LOAD     = 1'b1;
        tick();
        LOAD     = 1'b0;
    endtask

    // Stop on the first lit cycle of a digit slot on dut_a (guard -> target).
    task automatic wait_first(input logic [3:0] target, output logic found);
        logic [3:0] prev;
        prev  = dig_a;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev == 4'hF && dig_a == target) found = 1'b1;
            else prev = dig_a;
        end
    endtask

    task automatic check_digit(input int dg, input logic [7:0] exp_seg);
        logic [3:0] sel;
        logic       ok;
        sel = ~(4'b0001 << dg);
        wait_first(sel, ok);
        check($sformatf("dig%0d_found", dg), ok, 1'b1);
        check($sformatf("dig%0d_sel", dg), dig_a, sel);
        check($sformatf("dig%0d_seg", dg), seg_a, exp_seg);
    endtask

    // ---------------- directed vectors ----------------
    // Hand-decoded active-low SEGMENT values, ordered digit0..digit3.
    logic [31:0] v_data [6];
    logic [3:0]  v_dp   [6];
    logic [7:0]  v_seg  [6][4];

    // Reset scan: DIG after edge t for t=1..16 (one F guard per slot).
    logic [3:0] scan_tbl [16];
    // Coincidence: DIG/SEGMENT after edges t=4..14.
    logic [3:0] co_dig [11];
    logic [7:0] co_seg [11];
    // Blink: digit1 at t=16k+7 for frames k=0..5.
    logic [3:0] bl_dig [6];
    logic [7:0] bl_seg [6];

    initial begin
        v_data[0] = "1234"; v_dp[0] = 4'b0001; v_seg[0] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
        v_data[1] = "#Aa "; v_dp[1] = 4'b0000; v_seg[1] = '{8'hFF, 8'h88, 8'h88, 8'hFF};
        v_data[2] = "H-_p"; v_dp[2] = 4'b0000; v_seg[2] = '{8'h8C, 8'hF7, 8'hBF, 8'h89};
        v_data[3] = "E0L9"; v_dp[3] = 4'b1010; v_seg[3] = '{8'h90, 8'h47, 8'hC0, 8'h06};
        v_data[4] = "bcdf"; v_dp[4] = 4'b0000; v_seg[4] = '{8'h8E, 8'hA1, 8'hC6, 8'h83};
        v_data[5] = "5678"; v_dp[5] = 4'b0100; v_seg[5] = '{8'h80, 8'hF8, 8'h02, 8'h92};

        scan_tbl = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                     4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
        co_dig = '{4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7};
        co_seg = '{8'hFF, 8'hFF, 8'hC6, 8'hC6, 8'hC6, 8'hFF, 8'h83, 8'h83, 8'h83, 8'hFF, 8'h88};
        bl_dig = '{4'hD, 4'hD, 4'hF, 4'hF, 4'hD, 4'hD};
        bl_seg = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic       ok;
        logic       got;
        int         lit_cnt0;
        int         lit_cnt1;

        RST_N    = 1'b0;
        DATA     = '0;
        DP       = '0;
        LOAD     = 1'b0;
        BLINK_EN = '0;
        BRIGHT   = 4'd15;
        ENABLE   = 1'b1;

        // ---- reset asserted mid-slot ----
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        t = 0;
        tick();
        tick();
        check("pre_rst_dig", dig_a, 4'hE);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_seg", seg_a, 8'hFF);
        check("rst_dig", dig_a, 4'hF);
        check("rst_fd", fd_a, 1'b0);

        // ---- blank scan after release ----
        do_reset();
        while (t < 32) begin
            tick();
            check("scan_dig", dig_a, scan_tbl[(t - 1) % 16]);
            check("scan_seg", seg_a, 8'hFF);
            check("scan_fd", fd_a, (t % 16) == 0);
        end

        // ---- decode ----
        for (int v = 0; v < 6; v++) begin
            load(v_data[v], v_dp[v], 4'b0000);
            for (int d = 0; d < 4; d++) begin
                check_digit(d, v_seg[v][d]);
            end
        end

        // ---- load isolation ----
        load("1234", 4'b0001, 4'b0000);
        check_digit(0, 8'h19);
        DATA = "8888";
        DP   = 4'b0000;
        check_digit(0, 8'h19);
        check_digit(3, 8'hF9);
        wait_first(4'hE, ok);
        check("mid_found", ok, 1'b1);
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        check("mid_old_seg", seg_a, 8'h19);
        check("mid_old_dig", dig_a, 4'hE);
        tick();
        check("mid_new_seg", seg_a, 8'h80);
        check("mid_new_dig", dig_a, 4'hE);

        // ---- brightness on the long-slot instance ----
        BRIGHT = 4'd3;
        do_reset();
        lit_cnt0 = 0;
        lit_cnt1 = 0;
        while (t < 66) begin
            tick();
            if (t >= 2 && t <= 17 && dig_b != 4'hF) lit_cnt0++;
            if (t >= 18 && t <= 33 && dig_b != 4'hF) lit_cnt1++;
            if (t == 1)  check("br_guard_dig", dig_b, 4'hF);
            if (t == 2)  check("br_lit_dig", dig_b, 4'hE);
            if (t == 5)  check("br_dark_dig", dig_b, 4'hF);
            if (t == 5)  check("br_dark_seg", seg_b, 8'hFF);
            if (t == 17) check("br_wrap_dig", dig_b, 4'hE);
            if (t == 65) check("br_slot1_guard", dig_b, 4'hF);
            if (t == 66) check("br_slot1_lit", dig_b, 4'hD);
        end
        check("br_window0", lit_cnt0, 4);
        check("br_window1", lit_cnt1, 4);

        // ---- ENABLE=0 ----
        BRIGHT = 4'd15;
        wait_first(4'hE, ok);
        check("en_found", ok, 1'b1);
        ENABLE = 1'b0;
        tick();
        check("en_off_dig", dig_a, 4'hF);
        check("en_off_seg", seg_a, 8'hFF);
        got = 1'b0;
        for (int i = 0; i < 24 && !got; i++) begin
            tick();
            check("en_dark_dig", dig_a, 4'hF);
            if (fd_a) got = 1'b1;
        end
        check("en_frame_done", got, 1'b1);
        ENABLE = 1'b1;

        // ---- blink ----
        do_reset();
        load("8888", 4'b0000, 4'b0010);
        while (t < 96) begin
            tick();
            if (t % 16 == 7) begin
                check("blink_d1_dig", dig_a, bl_dig[t / 16]);
                check("blink_d1_seg", seg_a, bl_seg[t / 16]);
            end
            if (t % 16 == 11) begin
                check("blink_d2_dig", dig_a, 4'hB);
                check("blink_d2_seg", seg_a, 8'h80);
            end
        end

        // ---- LOAD coincident with a slot wrap (edge 4) ----
        do_reset();
        DATA = "ABCD";
        DP   = 4'b0000;
        BLINK_EN = 4'b0000;
        while (t < 3) tick();
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        check("co_dig", dig_a, co_dig[0]);
        check("co_seg", seg_a, co_seg[0]);
        while (t < 14) begin
            tick();
            check("co_dig", dig_a, co_dig[t - 4]);
            check("co_seg", seg_a, co_seg[t - 4]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
